// File: rtl/instr_feeder.sv
// instr_feeder: feeds 9-bit instruction words from a small loadable program
// store to the processor's Din input. It sequences the Run/Done handshake,
// advances the program counter on Done or on an immediate-operand acknowledge,
// and trips a watchdog if the processor stalls in WAIT.
module instr_feeder #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [8:0]        wr_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              abort,
    input  logic              cpu_done,
    input  logic              cpu_imm_ack,
    output logic [8:0]        din,
    output logic              run,
    output logic [ADDR_W:0]   pc,
    output logic              busy,
    output logic              finished,
    output logic              fault,
    output logic              wr_rej
);

    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]   WD_ONE = WD_W'(1);
    localparam logic [ADDR_W:0]   PC_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   PC_TWO = (ADDR_W+1)'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_FAULT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W:0]   pc_n;
    logic [ADDR_W:0]   len_q, len_n;
    logic [WD_W-1:0]   wdog, wdog_n;
    logic [ADDR_W:0]   pc_done;
    logic [8:0]        mem [DEPTH];
    logic [8:0]        rd_word;

    // Done advances past the current word, plus the operand word when the
    // immediate acknowledge arrives in the same cycle.
    assign pc_done = cpu_imm_ack ? (pc + PC_TWO) : (pc + PC_ONE);

    // The store is DEPTH deep; a pc that overshoots via an operand ack wraps.
    assign rd_word = mem[pc[ADDR_W-1:0]];

    // Outputs decoded straight from state so reset clears them immediately.
    assign busy = (state == S_ISSUE) || (state == S_WAIT);
    assign run  = (state == S_ISSUE);
    assign din  = busy ? rd_word : 9'd0;

    // Next-state, program counter, length latch and watchdog.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        len_n   = len_q;
        wdog_n  = wdog;
        if (abort) begin
            state_n = S_IDLE;
            pc_n    = '0;
        end else begin
            case (state)
                S_IDLE, S_FINISH, S_FAULT: begin
                    if (start) begin
                        len_n   = prog_len;
                        pc_n    = '0;
                        state_n = (prog_len == '0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_n = S_WAIT;
                    wdog_n  = '0;
                end
                S_WAIT: begin
                    if (cpu_done) begin
                        pc_n    = pc_done;
                        state_n = (pc_done >= len_q) ? S_FINISH : S_ISSUE;
                        wdog_n  = wdog + WD_ONE;
                    end else if (cpu_imm_ack) begin
                        pc_n   = pc + PC_ONE;
                        wdog_n = '0;
                    end else if (wdog == WD_MAX) begin
                        state_n = S_FAULT;
                    end else begin
                        wdog_n = wdog + WD_ONE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    pc_n    = '0;
                end
            endcase
        end
    end

    // Control registers; finished/fault follow the state they flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            len_q    <= '0;
            wdog     <= '0;
            finished <= 1'b0;
            fault    <= 1'b0;
            wr_rej   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            len_q    <= len_n;
            wdog     <= wdog_n;
            finished <= (state_n == S_FINISH);
            fault    <= (state_n == S_FAULT);
            wr_rej   <= wr_en && busy;
        end
    end

    // Program store: loadable only while no program is executing.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: randomized programs and CPU responses, with a
// queue of expected Din words checked on every Run pulse by a monitor.
module tb_instr_feeder;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        wr_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              abort;
    logic              cpu_done;
    logic              cpu_imm_ack;
    logic [8:0]        din;
    logic              run;
    logic [ADDR_W:0]   pc;
    logic              busy;
    logic              finished;
    logic              fault;
    logic              wr_rej;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] model_mem [DEPTH];
    logic [8:0] exp_q [$];

    instr_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .prog_len(prog_len), .start(start), .abort(abort),
        .cpu_done(cpu_done), .cpu_imm_ack(cpu_imm_ack), .din(din), .run(run),
        .pc(pc), .busy(busy), .finished(finished), .fault(fault),
        .wr_rej(wr_rej)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every Run pulse must present the next expected word.
    always @(negedge clk) begin
        if (run) begin
            if (exp_q.size() == 0) check("unexpected_run", 1, 0);
            else check("run_din", int'(din), int'(exp_q.pop_front()));
        end
    end

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (run) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("run_timeout", 0, 1);
    endtask

    task automatic write_word(input int a, input logic [8:0] d);
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    // mode: 0 done only, 1 ack then done, 2 both together, -1 random per word.
    // inj: 1 refused write in first WAIT, 2 write to word 0 alongside start.
    task automatic run_program(input int len, input int mode, input int inj);
        int         types [$];
        int         p;
        int         t;
        bit         ok;
        logic [8:0] v;
        v = 9'($urandom);
        if (inj == 2) model_mem[0] = v;
        p = 0;
        while (p < len) begin
            t = (mode < 0) ? int'($urandom_range(0, 2)) : mode;
            exp_q.push_back(model_mem[p % DEPTH]);
            types.push_back(t);
            p += (t == 0) ? 1 : 2;
        end
        prog_len = (ADDR_W+1)'(len);
        start = 1'b1;
        if (inj == 2) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = v;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        if (len == 0) begin
            check("len0_finished", int'(finished), 1);
            check("len0_busy", int'(busy), 0);
            check("len0_pc", int'(pc), 0);
            return;
        end
        check("start_clears_finished", int'(finished), 0);
        check("start_clears_fault", int'(fault), 0);
        check("start_to_run", int'(run), 1);
        p = 0;
        for (int k = 0; k < types.size(); k++) begin
            wait_run(ok);
            if (!ok) return;
            @(negedge clk);
            if (inj == 1 && k == 0) begin
                wr_en = 1'b1; wr_addr = 4'd3; wr_data = 9'h1AA;
                @(negedge clk);
                wr_en = 1'b0;
                check("wr_rej_pulse", int'(wr_rej), 1);
                @(negedge clk);
                check("wr_rej_clear", int'(wr_rej), 0);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case (types[k])
                0: begin
                    cpu_done = 1'b1; @(negedge clk); cpu_done = 1'b0;
                    p += 1;
                end
                1: begin
                    cpu_imm_ack = 1'b1; @(negedge clk); cpu_imm_ack = 1'b0;
                    check("ack_pc", int'(pc), p + 1);
                    check("ack_din", int'(din), int'(model_mem[(p + 1) % DEPTH]));
                    check("ack_busy", int'(busy), 1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    cpu_done = 1'b1; @(negedge clk); cpu_done = 1'b0;
                    p += 2;
                end
                default: begin
                    cpu_done = 1'b1; cpu_imm_ack = 1'b1; @(negedge clk);
                    cpu_done = 1'b0; cpu_imm_ack = 1'b0;
                    p += 2;
                end
            endcase
            check("step_pc", int'(pc), p);
            if (k < types.size() - 1) begin
                check("done_to_run", int'(run), 1);
            end else begin
                check("end_finished", int'(finished), 1);
                check("end_busy", int'(busy), 0);
                check("end_run", int'(run), 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        bit ok;
        int cnt;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
        start = 1'b0; abort = 1'b0; cpu_done = 1'b0; cpu_imm_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_din", int'(din), 0);
        check("rst_run", int'(run), 0);
        check("rst_pc", int'(pc), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_finished", int'(finished), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_wr_rej", int'(wr_rej), 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(i, 9'($urandom));

        // Three plain instructions.
        write_word(0, 9'h040); write_word(1, 9'h0C1); write_word(2, 9'h1FF);
        run_program(3, 0, 0);
        // Immediate operand acknowledged before Done.
        write_word(0, 9'h050); write_word(1, 9'h005);
        run_program(2, 1, 0);
        // Done and ack together step by two.
        run_program(4, 2, 0);
        // Refused write while busy, then rerun reading the untouched word 3.
        run_program(4, 0, 1);
        run_program(4, 0, 0);
        // Write landing on the same edge as start.
        run_program(1, 0, 2);
        // Empty program.
        run_program(0, 0, 0);
        // Abort together with start from FINISH.
        abort = 1'b1; start = 1'b1; prog_len = 5'd3;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_start_finished", int'(finished), 0);
        check("abort_start_busy", int'(busy), 0);
        check("abort_start_pc", int'(pc), 0);
        @(negedge clk);
        check("abort_start_run", int'(run), 0);

        // Watchdog: no response at all.
        exp_q.push_back(model_mem[0]);
        prog_len = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_run(ok);
        cnt = 0;
        while (!fault && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("wdog_cycles", cnt, TIMEOUT + 2);
        check("fault_busy", int'(busy), 0);
        check("fault_din", int'(din), 0);
        run_program(1, 0, 0);

        // Abort in WAIT beats a simultaneous Done.
        exp_q.push_back(model_mem[0]);
        prog_len = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_run(ok);
        @(negedge clk);
        abort = 1'b1; cpu_done = 1'b1;
        @(negedge clk);
        abort = 1'b0; cpu_done = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_pc", int'(pc), 0);
        check("abort_din", int'(din), 0);

        // Asynchronous reset mid-WAIT.
        write_word(0, 9'h155);
        exp_q.push_back(model_mem[0]);
        prog_len = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_run(ok);
        @(negedge clk);
        check("pre_rst_din", int'(din), 9'h155);
        #2 rst = 1'b1;
        #1;
        check("async_rst_din", int'(din), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_pc", int'(pc), 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized programs.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < DEPTH; i++) write_word(i, 9'($urandom));
            run_program(int'($urandom_range(1, DEPTH)), -1,
                        ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        repeat (2) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Drives the processor's 9-bit Din input from a small loadable program store and sequences the processor's Run/Done handshake.
- Issues one instruction per Run pulse and advances its program counter on Done, or on an operand-consumed acknowledge for immediate words.
- Detects a processor that never completes an instruction via a watchdog.
- Sits between the board-level loader (switches/host) and the CPU top.

Parameters:
- DEPTH, 16, number of 9-bit program words.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W.
- TIMEOUT, 15, maximum cycles spent in WAIT before FAULT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  program-store write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  9  write data.
- prog_len  input  ADDR_W+1  program length in words, 0..DEPTH; sampled on start.
- start  input  1  begin execution from address 0.
- abort  input  1  return to IDLE immediately.
- cpu_done  input  1  CPU pulse: current instruction complete.
- cpu_imm_ack  input  1  CPU pulse: operand word on din latched.
- din  output  9  word presented to the CPU.
- run  output  1  one-cycle Run pulse to the CPU.
- pc  output  ADDR_W+1  current word address.
- busy  output  1  high in ISSUE or WAIT.
- finished  output  1  sticky end-of-program flag.
- fault  output  1  sticky watchdog flag.
- wr_rej  output  1  one-cycle pulse when a write is refused.

Behaviour:
- Reset, asynchronous, rst=1: state=IDLE, pc=0, len_q=0, wdog=0. All outputs 0. Program store contents are not reset.
- All state, pc, len_q, wdog, finished, fault and wr_rej are registered. din, run and busy decode combinationally from state and pc.
- States:
  - IDLE, FINISH, FAULT: run=0, din=0.
  - ISSUE: run=1, din=mem[pc].
  - WAIT: run=0, din=mem[pc].
- IDLE: on start, len_q<=prog_len and pc<=0. Go to FINISH if prog_len==0, otherwise ISSUE.
- ISSUE: lasts exactly one cycle, then WAIT with wdog<=0.
- WAIT, increment wdog each cycle with pc step chosen as follows:
  - cpu_done only: pc<=pc+1.
  - cpu_imm_ack only: pc<=pc+1 and stay in WAIT with wdog<=0.
  - Both in the same cycle: pc<=pc+2.
  - After any step that includes cpu_done: if the new pc >= len_q, go to FINISH; otherwise go to ISSUE.
  - cpu_imm_ack that moves pc >= len_q: stay in WAIT; din reads mem[pc mod DEPTH].
  - wdog==TIMEOUT with neither strobe asserted: go to FAULT.
- FINISH: finished=1. start restarts as from IDLE and clears finished on the same edge.
- FAULT: fault=1, pc holds. Only start (restart, clears fault) or abort/rst leave this state.
- abort, any state: next state IDLE, pc<=0, finished and fault cleared. abort has priority over start and over CPU strobes in the same cycle.
- cpu_done and cpu_imm_ack are ignored outside WAIT.
- Writes:
  - Accepted in IDLE, FINISH and FAULT: mem[wr_addr]<=wr_data on the clock edge.
  - In ISSUE or WAIT the write is discarded and wr_rej=1 for the following cycle.
- A write and a start in the same IDLE cycle: the write lands. The first ISSUE then reads the updated word if wr_addr==0.
- pc width ADDR_W+1; it cannot overflow because len_q <= DEPTH and the pc+2 overshoot is bounded by DEPTH+1.
- Latency: start to run=1 is 1 cycle. cpu_done to the next run=1 is 1 cycle.

Test Plan:
- Load mem[0..2]=9'h040,9'h0C1,9'h1FF with prog_len=3, pulse start; answer each run with cpu_done after 3 cycles. Required: three run pulses with din=040, 0C1, 1FF in turn, then finished=1 and pc=3.
- mem[0]=9'h050 (mvi), mem[1]=9'h005 (immediate), prog_len=2. Pulse cpu_imm_ack 2 cycles after run, then cpu_done. Required: din changes 050→005 after the ack, then finished with exactly one run pulse.
- Assert cpu_done and cpu_imm_ack together in WAIT at pc=0 with prog_len=4. Required: pc=2, next run presents mem[2].
- Run with no CPU response. Required: fault=1 exactly TIMEOUT+1 cycles after entering WAIT. A subsequent start clears fault and issues from pc=0.
- wr_en with wr_addr=3 and wr_data=9'h1AA while in WAIT. Required: wr_rej pulses 1 cycle and mem[3] is unchanged after finishing (read back via a rerun).
- Edge cases:
  - prog_len=0 plus start: FINISH next cycle, no run pulse.
  - rst asserted mid-WAIT: all outputs 0 immediately, without waiting for a clock edge.
  - abort and start in the same cycle: IDLE.
